// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, stall constants and fetch state encodings
package if_fetch_pkg;

    localparam int BYTE_BUS      = 8;
    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam logic NO_STOP = 1'b0;
    localparam logic STOP    = 1'b1;

    localparam logic [2:0] BYTES_PER_INST = 3'd4;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_LOAD  = 2'd1,
        IF_FETCH = 2'd2,
        IF_HOLD  = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_byte_asm.sv
// rtl/if_byte_asm.sv - collects four returned bytes into a little-endian instruction word
module if_byte_asm
    import if_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                grant,
    input  logic [BYTE_BUS-1:0] din,
    output logic [INST_BUS-1:0] word,
    output logic                done
);

    logic [BYTE_BUS-1:0] b0_q, b1_q, b2_q;
    logic [1:0]          cap_cnt;
    logic                pend_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            cap_cnt <= '0;
            pend_q  <= 1'b0;
        end else if (clr) begin
            // a byte still in flight from an abandoned request is dropped here
            cap_cnt <= '0;
            pend_q  <= 1'b0;
        end else begin
            pend_q <= grant;
            if (pend_q) begin
                case (cap_cnt)
                    2'd0:    b0_q <= din;
                    2'd1:    b1_q <= din;
                    2'd2:    b2_q <= din;
                    default: ;
                endcase
                cap_cnt <= cap_cnt + 2'd1;
            end
        end
    end

    // the top byte is taken straight from the bus on the cycle it arrives
    assign done = pend_q && (cap_cnt == 2'd3) && !clr;
    assign word = {din, b2_q, b1_q, b0_q};

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch over a byte-wide shared memory port
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                ce_i,
    input  logic                flush_i,
    input  logic                stall_i,
    input  logic                mem_gnt_i,
    input  logic [BYTE_BUS-1:0] mem_din_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_a_o,
    output logic [ADDR_W-1:0]   if_pc_o,
    output logic [INST_W-1:0]   if_inst_o,
    output logic                if_valid_o,
    output logic                stallreq_o
);

    if_state_e           state, state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [2:0]          issue_cnt;
    logic                grant;
    logic                asm_clr;
    logic                asm_done;
    logic [INST_W-1:0]   asm_word;

    assign grant   = mem_req_o && mem_gnt_i;
    assign asm_clr = (state != IF_FETCH) || flush_i || !ce_i;

    if_byte_asm u_byte_asm (
        .clk   (clk),
        .rst   (rst),
        .clr   (asm_clr),
        .grant (grant),
        .din   (mem_din_i),
        .word  (asm_word),
        .done  (asm_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IF_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!ce_i) begin
            state_nxt = IF_IDLE;
        end else begin
            case (state)
                IF_IDLE:  state_nxt = IF_LOAD;
                IF_LOAD:  state_nxt = flush_i ? IF_LOAD : IF_FETCH;
                IF_FETCH: begin
                    if (flush_i)       state_nxt = IF_LOAD;
                    else if (asm_done) state_nxt = IF_HOLD;
                end
                IF_HOLD:  begin
                    if (flush_i || !stall_i) state_nxt = IF_LOAD;
                end
                default:  state_nxt = IF_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_o  = 1'b0;
        mem_a_o    = '0;
        stallreq_o = NO_STOP;
        if (state == IF_FETCH && ce_i && !flush_i && issue_cnt < BYTES_PER_INST) begin
            mem_req_o = 1'b1;
            mem_a_o   = base_q + {{(ADDR_W-3){1'b0}}, issue_cnt};
        end
        if ((state == IF_LOAD || state == IF_FETCH) && !flush_i)
            stallreq_o = STOP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q     <= '0;
            issue_cnt  <= '0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
        end else if (!ce_i) begin
            base_q     <= '0;
            issue_cnt  <= '0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
        end else if (flush_i && state != IF_IDLE) begin
            issue_cnt  <= '0;
            if_valid_o <= 1'b0;
        end else begin
            case (state)
                IF_LOAD: begin
                    base_q    <= pc_i;
                    issue_cnt <= '0;
                end
                IF_FETCH: begin
                    if (grant) issue_cnt <= issue_cnt + 3'd1;
                    if (asm_done) begin
                        if_valid_o <= 1'b1;
                        if_pc_o    <= base_q;
                        if_inst_o  <= asm_word;
                    end
                end
                IF_HOLD: begin
                    if (!stall_i) if_valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current pc/ce and reads the 32-bit instruction over the byte-wide shared memory port as four byte reads.
- Presents {pc, inst} to the IF/ID latch with a valid/stall handshake.
- Raises a stall request to the pipeline controller while a fetch is in flight, so the PC register holds pc until the instruction has been consumed.

Parameters:
- ADDR_W, 32, address and pc width.
- INST_W, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pc_i  in  ADDR_W  pc from the PC register.
- ce_i  in  1  fetch enable from the PC register.
- flush_i  in  1  taken branch/jump from ID or EX; discard the current fetch.
- stall_i  in  1  downstream (IF/ID) hold; the instruction is not accepted this cycle.
- mem_gnt_i  in  1  memory arbiter grants the fetch port this cycle; data/load stage has priority.
- mem_din_i  in  8  read byte, valid one cycle after a granted request.
- mem_req_o  out  1  fetch requests the memory port.
- mem_a_o  out  ADDR_W  byte address of the request.
- if_pc_o  out  ADDR_W  pc of the presented instruction.
- if_inst_o  out  INST_W  assembled instruction, little-endian.
- if_valid_o  out  1  if_pc_o/if_inst_o are valid.
- stallreq_o  out  1  stall request to the pipeline controller.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs and internal registers are 0.
- State IDLE:
  - Entered when ce_i=0; all outputs 0.
  - ce_i=1 → LOAD.
- State LOAD (1 cycle):
  - base_q <= pc_i; issue_cnt=0; cap_cnt=0.
  - No memory request; stallreq_o=1.
  - → FETCH.
- State FETCH:
  - mem_req_o=1 while issue_cnt<4; mem_a_o = base_q + issue_cnt, computed modulo 2^ADDR_W (wraps past all-ones).
  - A request is granted when mem_req_o && mem_gnt_i; on a grant, issue_cnt increments and pend_q <= 1, otherwise pend_q <= 0.
  - When pend_q=1, byte[cap_cnt] <= mem_din_i and cap_cnt increments.
  - stallreq_o=1.
  - When the fourth byte is captured: if_inst_o <= {b3,b2,b1,b0}, if_pc_o <= base_q, if_valid_o <= 1 → HOLD.
  - Nominal latency with continuous grant: LOAD in cycle 0, requests in cycles 1–4, captures at the ends of cycles 2–5, if_valid_o high from cycle 6.
  - A grant gap of N cycles adds exactly N cycles of latency; byte order is preserved.
- State HOLD:
  - stallreq_o=0; mem_req_o=0.
  - if_valid_o && !stall_i marks consumption (the PC register advances on the same edge): next state LOAD, if_valid_o <= 0.
  - With stall_i=1, outputs are held unchanged for any number of cycles.
- flush_i=1 in LOAD, FETCH or HOLD:
  - At the next edge: if_valid_o <= 0, pend_q <= 0, counters cleared → LOAD.
  - A byte still returning from a request already granted is ignored.
  - mem_req_o is forced to 0 in the flush cycle.
  - flush_i has priority over consumption and over the fourth-byte capture.
- ce_i=0 in any state → IDLE at the next edge, outputs cleared; flush_i is ignored when ce_i=0.
- stallreq_o = (state==LOAD || state==FETCH) && !flush_i.
- mem_a_o is 0 whenever mem_req_o=0.
- Reset asserted mid-fetch clears everything immediately; no memory request is issued until ce_i=1 again after reset is released.

Decomposition:
- Shared package/defines header holds:
  - state encodings IF_IDLE, IF_LOAD, IF_FETCH, IF_HOLD;
  - ByteBus, InstAddrBus and InstBus width macros;
  - the NoStop/Stop constants.
- One natural sub-module, if_byte_asm: 4×8 capture registers, cap_cnt and pend_q, producing the assembled word plus a done strobe.
- The FSM and address generation stay in if_fetch.

Test Plan:
- Continuous grant, pc_i=0x0000_1000, memory bytes 0x13,0x05,0x10,0x00 → requests to 0x1000–0x1003 in cycles 1–4; if_valid_o=1 in cycle 6 with if_inst_o=0x0010_0513, if_pc_o=0x1000; stallreq_o=1 in cycles 0–5.
- mem_gnt_i low for cycles 2–3 during FETCH → if_valid_o in cycle 8; instruction is unchanged and bytes are in order.
- HOLD with stall_i=1 for 5 cycles then 0 → outputs stable for 5 cycles; LOAD of the new pc_i=0x1004 on the following cycle.
- flush_i pulsed in the cycle the third byte is requested, pc_i becomes 0x2000 → late byte discarded; the next fetch reads 0x2000–0x2003; no valid is produced for 0x1000.
- pc_i=0xFFFF_FFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wrap).
- rst driven low asynchronously mid-FETCH → outputs 0 immediately without a clock edge; after release with ce_i=1, LOAD, then requests restart from the current pc_i.
